led_fade_pwm: RTL
=================

// Module: led_fade_pwm
// PURPOSE
//  Downstream LED output stage for PYNQ-Z2. Turns per-LED on/off requests (blink patterns) into
//  soft-fading PWM drive for the 4 user LEDs. Each channel ramps its duty toward a target one step
//  per fade tick, then drives its pin from a shared 8-bit PWM counter. Brightness cap via max_duty.
// PARAMETERS
//  PWM_DIV   4        sysclk cycles per PWM count; PWM period = 256*PWM_DIV cycles (>=1)
//  FADE_DIV  122_070  sysclk cycles per duty step; full 0->255 ramp ~0.25 s at 125 MHz (>=1)
//  NUM_LED   4        number of LED channels
// PORTS
//  sysclk    in   1        system clock, 125 MHz
//  rst       in   1        reset, asynchronous, active-high
//  led_req   in   NUM_LED  per-channel on request from the blink pattern stage
//  max_duty  in   8        brightness cap; on-target duty for every channel
//  led       out  NUM_LED  registered PWM drive to the LED pins
//  settled   out  NUM_LED  registered; 1 = channel duty equals its target
// BEHAVIOUR
//  Reset: async assert clears every register; led=0, settled=0, all duty/shadow/counters=0.
//   Reset mid-ramp: led drops to 0 with no clock edge; after release, ramps restart from duty 0.
//  Prescalers: pre_cnt counts 0..PWM_DIV-1, pwm_tick when pre_cnt==PWM_DIV-1; fd_cnt counts
//   0..FADE_DIV-1, fade_tick when fd_cnt==FADE_DIV-1. Widths $clog2(DIV), min 1 bit.
//  pwm_cnt (8b) increments on pwm_tick, wraps 255->0. period_start = pwm_tick && pwm_cnt==255.
//  Target: target[i] = led_req[i] ? max_duty : 8'd0, evaluated every cycle (inputs sync to sysclk).
//  Ramp on fade_tick: duty<target -> +1; duty>target -> -1; equal -> hold. Step is exactly 1, no
//   saturation needed (never crosses target). Req toggle mid-ramp reverses at next fade_tick, no jump.
//   Lowering max_duty below duty ramps down the same way.
//  Shadow: duty_sh[i] <= duty[i] on period_start only; PWM width never changes mid-period.
//   fade_tick and period_start in same cycle: shadow captures pre-step duty (new value next period).
//  Output: led[i] <= (duty_sh[i]==8'hFF) | (pwm_cnt < duty_sh[i]); 1-cycle registered latency.
//   duty_sh=0 -> constant 0; 8'hFF -> constant 1; else high for duty_sh*PWM_DIV cycles per period.
//  settled[i] <= (duty[i]==target[i]); reflects state one cycle late.
//  No handshakes; block is free-running, no stall conditions.
// STRUCTURE
//  Package led_pkg: NUM_LED=4, DUTY_W=8, DUTY_MAX=8'hFF, SYSCLK_HZ=125_000_000.
//  Sub-module led_fade_channel (one per LED): duty ramp, shadow, compare, settled flag.
//   Inputs: sysclk, rst, fade_tick, period_start, pwm_cnt, target. Generate-loop NUM_LED copies.
//  Top holds shared prescalers, pwm_cnt, target muxing.
// TESTING (bench params PWM_DIV=2, FADE_DIV=4; period = 512 cycles)
//  1 Reset: rst=1, led_req=4'hF, max_duty=8'hFF for 2000 cycles -> led=0, settled=0 throughout.
//  2 Ramp up: release rst, led_req=4'b0001, max_duty=8'hFF -> duty0 hits 255 after 255 fade ticks
//    (1020 cycles), settled[0]=1 one cycle later; led[0] constant 1 from period_start+1 onward;
//    led[3:1]=0, settled[3:1]=1.
//  3 Cap: max_duty=64, led_req=4'b0010, after settle -> led[1] high exactly 128 of every 512 cycles.
//  4 Reverse: led_req[2]=1 until duty2=100, then 0 -> duty2 steps 100->0 one per fade tick,
//    no step >1; settled[2]=1 when 0; led[2] constant 0 after next period_start.
//  5 Shadow + collision: force fade_tick on period_start cycle -> captured width is old duty;
//    new width appears only in following period; high-time inside a period never changes.
//  6 Async reset mid-ramp (duty=50): pulse rst between clock edges -> led=0 immediately,
//    post-release ramp restarts from 0 and matches scenario 2 timing.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade/PWM output stage.
package led_pkg;

  localparam int unsigned NUM_LED   = 4;
  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned SYSCLK_HZ = 125_000_000;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = 8'hFF;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: duty ramp toward target, per-period shadow, PWM compare and settled flag.
module led_fade_channel
  import led_pkg::*;
(
  input  logic  sysclk,
  input  logic  rst,
  input  logic  fade_tick,
  input  logic  period_start,
  input  duty_t pwm_cnt,
  input  duty_t target,
  output logic  led,
  output logic  settled
);

  duty_t duty;
  duty_t duty_sh;

  // Single-step ramp; a step of one can never overshoot the target.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      duty <= '0;
    end else if (fade_tick) begin
      if (duty < target) begin
        duty <= duty + DUTY_W'(1);
      end else if (duty > target) begin
        duty <= duty - DUTY_W'(1);
      end
    end
  end

  // Shadow latches the pre-step duty so the width is stable for a whole period.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      duty_sh <= '0;
    end else if (period_start) begin
      duty_sh <= duty;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      led     <= 1'b0;
      settled <= 1'b0;
    end else begin
      led     <= (duty_sh == DUTY_MAX) | (pwm_cnt < duty_sh);
      settled <= (duty == target);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Soft-fading PWM drive for the user LEDs: shared prescalers and PWM counter, one fade channel per LED.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_DIV  = 4,
  parameter int unsigned FADE_DIV = 122_070,
  parameter int unsigned NUM_LED  = led_pkg::NUM_LED
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [NUM_LED-1:0] led_req,
  input  logic [7:0]         max_duty,
  output logic [NUM_LED-1:0] led,
  output logic [NUM_LED-1:0] settled
);

  localparam int unsigned PRE_W = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int unsigned FD_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [FD_W-1:0]  fd_cnt;
  duty_t            pwm_cnt;
  logic             pwm_tick;
  logic             fade_tick;
  logic             period_start;
  duty_t            target [NUM_LED];

  assign pwm_tick     = (pre_cnt == PRE_W'(PWM_DIV - 1));
  assign fade_tick    = (fd_cnt == FD_W'(FADE_DIV - 1));
  assign period_start = pwm_tick && (pwm_cnt == DUTY_MAX);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      fd_cnt  <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= pwm_tick  ? '0 : pre_cnt + PRE_W'(1);
      fd_cnt  <= fade_tick ? '0 : fd_cnt + FD_W'(1);
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end
    end
  end

  // Requested channels aim at the brightness cap, idle ones at dark.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      target[i] = led_req[i] ? duty_t'(max_duty) : '0;
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    led_fade_channel u_ch (
      .sysclk       (sysclk),
      .rst          (rst),
      .fade_tick    (fade_tick),
      .period_start (period_start),
      .pwm_cnt      (pwm_cnt),
      .target       (target[g]),
      .led          (led[g]),
      .settled      (settled[g])
    );
  end

endmodule
